fb_pixel_writer: RTL and testbench
==================================

# fb_pixel_writer

Upstream pixel-write master for the 16-bit SRAM path. It accepts rasterized pixel writes (x, y, 32-bit colour) over a valid/ready stream and buffers them in a small FIFO. It converts each coordinate to a byte address in the framebuffer and issues 32-bit Avalon-MM writes to the 32→16 bus adapter, honouring its waitrequest. Optionally it also hosts a full-screen clear engine.

## Interface
Parameters:
- FIFO_DEPTH, 4, pixel FIFO entries; power of two, ≥2
- H_RES, 640, pixels per line
- V_RES, 480, lines per frame
- ADDR_W, 26, byte address width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low
- pix_valid  in  1  pixel request valid
- pix_ready  out  1  pixel request accepted when valid & ready
- pix_x  in  10  column
- pix_y  in  9  row
- pix_color  in  32  pixel colour
- fb_base  in  ADDR_W  framebuffer base byte address; quasi-static, sampled at push and at clear start
- master_address  out  ADDR_W  write byte address to adapter
- master_write  out  1  write request
- master_writedata  out  32  write data
- master_waitrequest  in  1  adapter stall
- clear_start  in  1  one-cycle clear request (FB_CLEAR_EN only)
- clear_color  in  32  clear colour, sampled with clear_start (FB_CLEAR_EN only)
- busy  out  1  work pending or in flight
- drop_count  out  16  saturating count of discarded out-of-range pixels

## Operation
- Push path: on pix_valid & pix_ready, if pix_x ≥ H_RES or pix_y ≥ V_RES, discard and increment drop_count, saturating at 0xFFFF. Otherwise push {addr, color}, with addr = fb_base + ((pix_y*H_RES + pix_x) << 2), truncated mod 2^ADDR_W.
- pix_ready = !fifo_full & !clear_pending & state≠CLEAR. It is computed from registers only; a pop in the same cycle does not free a slot early.
- FSM states: IDLE, WRITE, CLEAR (CLEAR exists only with FB_CLEAR_EN).
- IDLE, clear_pending & FIFO empty: → CLEAR.
- IDLE, otherwise FIFO non-empty: load the head into address/data registers, set master_write=1, → WRITE.
- WRITE: hold address, data and master_write stable while master_waitrequest=1. A write completes in a cycle with master_write=1 & master_waitrequest=0. On completion, pop the FIFO.
  - If a further entry is valid (count>1), load it and stay in WRITE (back-to-back writes).
  - Otherwise set master_write=0 and → IDLE.
- busy = (state≠IDLE) | fifo non-empty | clear_pending.
- Reset, including mid-operation: the FIFO is emptied, any in-flight write is abandoned, and master_write drops asynchronously.

## Timing
- Reset values: pix_ready=0 while reset asserted, 1 in the first cycle after release. master_write=0, master_address=0, master_writedata=0, busy=0, drop_count=0. state=IDLE, clear_pending=0.
- Latency: pixel accepted in cycle N → master_write high in cycle N+2, provided the FIFO was empty and the FSM idle.
- Throughput: one write per cycle while waitrequest=0 and the FIFO holds entries.
- FIFO full: pix_ready=0 until a pop has occurred, seen the following cycle.
- Empty FIFO in IDLE: no write issued. master_write is never asserted with stale data.
- Simultaneous push and pop: both take effect; count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. Count occupies log2(FIFO_DEPTH)+1 bits.

## Configuration
- FB_CLEAR_EN defined:
  - clear_start sets clear_pending, ignored if clear_pending is already set or state=CLEAR. clear_color and fb_base are latched at that point.
  - Queued pixels drain first. CLEAR then writes clear_color to fb_base, fb_base+4, … up to fb_base+(H_RES*V_RES−1)*4 using the same waitrequest rules and one write per cycle.
  - After the last write is accepted, clear_pending clears and the FSM returns to IDLE.
- FB_CLEAR_EN undefined: no clear_start/clear_color ports, no CLEAR state, clear_pending constant 0.

## Test plan
- Address mapping: H_RES=640, fb_base=0x100000, pixel (3,2) colour 0xDEADBEEF → single write with address 0x10140C, data 0xDEADBEEF, master_write high 2 cycles after acceptance.
- Waitrequest stall: hold master_waitrequest=1 for 5 cycles during a write → address and data unchanged for all 5 cycles; exactly one completed write; FIFO pops once.
- Full FIFO: FIFO_DEPTH=4, push 6 pixels with waitrequest=1 → pix_ready=0 after 4 accepts. Release waitrequest → all 6 written in order, back-to-back.
- Out-of-range pixels: push (640,0) and (0,480) → no writes issued, drop_count=2, busy stays 0.
- Reset mid-write: assert reset while master_write=1 with 3 entries queued → master_write=0 immediately. After release: no writes, busy=0, pix_ready=1.
- FB_CLEAR_EN, H_RES=4, V_RES=2, fb_base=0, clear_color=0x00FF00FF, issued with 1 pixel queued → the pixel is written first. Then 8 writes to 0x0..0x1C with 0x00FF00FF; pix_ready=0 throughout; busy falls after the last write.

Source files
------------

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer
// Pixel write master for the 16-bit SRAM path. It buffers rasterized pixel
// writes (x, y, colour) in a small FIFO, turns each coordinate into a
// framebuffer byte address and issues 32-bit Avalon-MM writes to the 32->16
// bus adapter, honouring its waitrequest.
//
// Optional feature macro: FB_CLEAR_EN adds the full-screen clear engine
// (clear_start / clear_color ports and the CLEAR state).
//
// Ports:
//   clock, reset          system clock (rising edge), async active-low reset
//   pix_valid/pix_ready   pixel request handshake
//   pix_x, pix_y          pixel column / row
//   pix_color             32-bit pixel colour
//   fb_base               framebuffer base byte address (quasi-static)
//   master_*              Avalon-MM write master towards the bus adapter
//   clear_start           one-cycle clear request (FB_CLEAR_EN only)
//   clear_color           clear colour, sampled with clear_start (FB_CLEAR_EN only)
//   busy                  work pending or in flight
//   drop_count            saturating count of discarded out-of-range pixels
//
// state | meaning
// IDLE  | no write on the bus; waiting for a FIFO entry or a pending clear
// WRITE | pixel write on the bus; FIFO head is the entry in flight
// CLEAR | clear engine sweeping the whole frame (FB_CLEAR_EN only)
module fb_pixel_writer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned H_RES      = 640,
    parameter int unsigned V_RES      = 480,
    parameter int unsigned ADDR_W     = 26
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [9:0]        pix_x,
    input  logic [8:0]        pix_y,
    input  logic [31:0]       pix_color,
    input  logic [ADDR_W-1:0] fb_base,
    output logic [ADDR_W-1:0] master_address,
    output logic              master_write,
    output logic [31:0]       master_writedata,
    input  logic              master_waitrequest,
`ifdef FB_CLEAR_EN
    input  logic              clear_start,
    input  logic [31:0]       clear_color,
`endif
    output logic              busy,
    output logic [15:0]       drop_count
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_W + 32;

`ifdef FB_CLEAR_EN
    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, CLEAR = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1} state_t;
`endif

    state_t             state_q, state_d;
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr, nxt_ptr;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty, fifo_full, fifo_push, fifo_pop;
    logic               push_accept, in_range;
    logic [31:0]        pix_linear;
    logic [ADDR_W-1:0]  push_addr;
    logic               clear_pending, in_clear;
    logic [ADDR_W-1:0]  addr_d;
    logic [31:0]        data_d;
    logic               write_d;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign nxt_ptr    = rd_ptr + 1'b1;

    // Gating with reset keeps ready low while reset is held even though
    // all state registers already read as empty.
    assign pix_ready   = reset & ~fifo_full & ~clear_pending & ~in_clear;
    assign push_accept = pix_valid & pix_ready;
    assign in_range    = (32'(pix_x) < H_RES) && (32'(pix_y) < V_RES);
    assign fifo_push   = push_accept & in_range;
    assign pix_linear  = 32'(pix_y) * H_RES + 32'(pix_x);
    assign push_addr   = fb_base + ADDR_W'(pix_linear << 2);

    assign busy = (state_q != IDLE) | ~fifo_empty | clear_pending;

    always_ff @(posedge clock) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= {push_addr, pix_color};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            drop_count <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop)  rd_ptr <= nxt_ptr;
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
            if (push_accept && !in_range && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

`ifdef FB_CLEAR_EN
    localparam int unsigned PIX_TOTAL = H_RES * V_RES;
    localparam int          CLR_W     = $clog2(PIX_TOTAL + 1);

    // Remaining clear writes, counting down to the terminal value 1.
    logic [CLR_W-1:0]  clr_left_q, clr_left_d;
    logic [31:0]       clear_color_q;
    logic [ADDR_W-1:0] clear_base_q;
    logic              clear_pending_q, clear_done;

    assign clear_pending = clear_pending_q;
    assign in_clear      = (state_q == CLEAR);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clr_left_q      <= '0;
            clear_color_q   <= '0;
            clear_base_q    <= '0;
            clear_pending_q <= 1'b0;
        end else begin
            clr_left_q <= clr_left_d;
            if (clear_done) begin
                clear_pending_q <= 1'b0;
            end else if (clear_start && !clear_pending_q && !in_clear) begin
                clear_pending_q <= 1'b1;
                clear_color_q   <= clear_color;
                clear_base_q    <= fb_base;
            end
        end
    end
`else
    assign clear_pending = 1'b0;
    assign in_clear      = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = master_address;
        data_d   = master_writedata;
        write_d  = master_write;
        fifo_pop = 1'b0;
`ifdef FB_CLEAR_EN
        clr_left_d = clr_left_q;
        clear_done = 1'b0;
`endif
        case (state_q)
            IDLE: begin
`ifdef FB_CLEAR_EN
                // Queued pixels drain before the clear sweep starts.
                if (clear_pending_q && fifo_empty) begin
                    addr_d     = clear_base_q;
                    data_d     = clear_color_q;
                    write_d    = 1'b1;
                    clr_left_d = CLR_W'(PIX_TOTAL);
                    state_d    = CLEAR;
                end else
`endif
                if (!fifo_empty) begin
                    {addr_d, data_d} = fifo_mem[rd_ptr];
                    write_d          = 1'b1;
                    state_d          = WRITE;
                end
            end
            WRITE: begin
                if (!master_waitrequest) begin
                    fifo_pop = 1'b1;
                    // The head is the write just completed; chain the next
                    // entry only if it was already present before this pop.
                    if (fifo_count > CNT_W'(1)) begin
                        {addr_d, data_d} = fifo_mem[nxt_ptr];
                    end else begin
                        write_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
`ifdef FB_CLEAR_EN
            CLEAR: begin
                if (!master_waitrequest) begin
                    if (clr_left_q == CLR_W'(1)) begin
                        write_d    = 1'b0;
                        clear_done = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        addr_d     = master_address + ADDR_W'(4);
                        clr_left_d = clr_left_q - 1'b1;
                    end
                end
            end
`endif
            default: begin
                write_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            master_address   <= '0;
            master_writedata <= '0;
            master_write     <= 1'b0;
        end else begin
            state_q          <= state_d;
            master_address   <= addr_d;
            master_writedata <= data_d;
            master_write     <= write_d;
        end
    end

endmodule

// File: tb/tb_fb_pixel_writer.sv
module tb_fb_pixel_writer;
    localparam int DEPTH = 4;
    localparam int HR    = 640;
    localparam int VR    = 480;
    localparam int AW    = 26;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [9:0]    pix_x = '0;
    logic [8:0]    pix_y = '0;
    logic [31:0]   pix_color = '0;
    logic [AW-1:0] fb_base = '0;
    logic [AW-1:0] master_address;
    logic          master_write;
    logic [31:0]   master_writedata;
    logic          master_waitrequest = 1'b0;
    logic          busy;
    logic [15:0]   drop_count;
`ifdef FB_CLEAR_EN
    logic          clear_start = 1'b0;
    logic [31:0]   clear_color = '0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int writes_done = 0;
    int w0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    fb_pixel_writer #(.FIFO_DEPTH(DEPTH), .H_RES(HR), .V_RES(VR), .ADDR_W(AW)) dut (
        .clock(clock), .reset(reset),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .fb_base(fb_base),
        .master_address(master_address), .master_write(master_write),
        .master_writedata(master_writedata), .master_waitrequest(master_waitrequest),
`ifdef FB_CLEAR_EN
        .clear_start(clear_start), .clear_color(clear_color),
`endif
        .busy(busy), .drop_count(drop_count)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t         exp_q[$];
    int unsigned model_drops = 0;
    logic        b2b_due = 1'b0;
    logic        hold_due = 1'b0;
    wr_t         hold_val;

    function automatic logic [AW-1:0] pix_addr(input logic [AW-1:0] base, input int x, input int y);
        longint off;
        off = (longint'(y) * HR + longint'(x)) * 4;
        return base + AW'(off);
    endfunction

    always @(negedge clock) begin
        logic exp_ready;
        wr_t  e;
        if (!reset) begin
            check("rst_ready", pix_ready, 0);
            check("rst_write", master_write, 0);
            exp_q.delete();
            model_drops = 0;
            b2b_due     = 1'b0;
            hold_due    = 1'b0;
        end else begin
            exp_ready = (exp_q.size() < DEPTH);
            check("pix_ready", pix_ready, exp_ready);
            check("busy", busy, exp_q.size() != 0);
            check("drop_count", drop_count, model_drops);
            if (master_write) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stale_write: write to 0x%0h issued, expected no write", master_address);
                end else begin
                    check("wr_addr", master_address, exp_q[0].addr);
                    check("wr_data", master_writedata, exp_q[0].data);
                end
            end
            if (b2b_due)  check("back_to_back", master_write, 1);
            if (hold_due) check("held_write", {master_write, master_address, master_writedata}, {1'b1, hold_val});
            // advance to the next rising edge
            hold_due = master_write && master_waitrequest;
            hold_val = {master_address, master_writedata};
            b2b_due  = 1'b0;
            if (master_write && !master_waitrequest && exp_q.size() > 0) begin
                b2b_due = (exp_q.size() > 1);
                void'(exp_q.pop_front());
                writes_done++;
            end
            if (pix_valid && exp_ready) begin
                if (pix_x < HR && pix_y < VR) begin
                    e.addr = pix_addr(fb_base, pix_x, pix_y);
                    e.data = pix_color;
                    exp_q.push_back(e);
                end else if (model_drops < 32'hFFFF) begin
                    model_drops++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Leaves pix_valid high on return so callers can stream back-to-back.
    task automatic send(input int x, input int y, input logic [31:0] c);
        pix_x     = x[9:0];
        pix_y     = y[8:0];
        pix_color = c;
        pix_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (pix_ready) begin
                step();
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: pixel (%0d,%0d) not accepted in 100 cycles, expected acceptance", x, y);
        step();
    endtask

    task automatic wait_write(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clock);
            if (master_write) return;
        end
        checks++;
        errors++;
        $display("FAIL write_timeout: master_write=0 after %0d cycles, expected 1", bound);
    endtask

`ifdef FB_CLEAR_EN
    logic        c_valid = 1'b0, c_ready, c_write, c_wait = 1'b0, c_busy, c_start = 1'b0;
    logic [9:0]  c_x = '0;
    logic [8:0]  c_y = '0;
    logic [31:0] c_color = '0, c_data, c_clr_color = '0;
    logic [AW-1:0] c_base = '0, c_addr;
    logic [15:0] c_drops;
    logic [AW-1:0] c_wa [16];
    logic [31:0]   c_wd [16];
    int c_n, c_last, c_fall;

    fb_pixel_writer #(.FIFO_DEPTH(DEPTH), .H_RES(4), .V_RES(2), .ADDR_W(AW)) u_clr (
        .clock(clock), .reset(reset),
        .pix_valid(c_valid), .pix_ready(c_ready),
        .pix_x(c_x), .pix_y(c_y), .pix_color(c_color), .fb_base(c_base),
        .master_address(c_addr), .master_write(c_write),
        .master_writedata(c_data), .master_waitrequest(c_wait),
        .clear_start(c_start), .clear_color(c_clr_color),
        .busy(c_busy), .drop_count(c_drops)
    );
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        check("reset_pix_ready", pix_ready, 0);
        check("reset_master_write", master_write, 0);
        check("reset_master_address", master_address, 0);
        check("reset_master_writedata", master_writedata, 0);
        check("reset_busy", busy, 0);
        check("reset_drop_count", drop_count, 0);
        step();
        reset = 1'b1;
        @(negedge clock);
        check("ready_after_release", pix_ready, 1);
        step();

        // address mapping and latency
        fb_base = 26'h100000;
        send(3, 2, 32'hDEADBEEF);
        pix_valid = 1'b0;
        @(negedge clock);
        check("latency_n1_write", master_write, 0);
        @(negedge clock);
        check("latency_n2_write", master_write, 1);
        check("map_address", master_address, 26'h10140C);
        check("map_data", master_writedata, 32'hDEADBEEF);
        repeat (3) step();
        check("map_write_count", writes_done, 1);

        // waitrequest stall
        master_waitrequest = 1'b1;
        w0 = writes_done;
        send(10, 1, 32'h11111111);
        pix_valid = 1'b0;
        wait_write(10);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clock);
            check("stall_address", master_address, 26'h100A28);
            check("stall_data", master_writedata, 32'h11111111);
            check("stall_write", master_write, 1);
        end
        step();
        master_waitrequest = 1'b0;
        repeat (4) step();
        check("stall_write_count", writes_done - w0, 1);
        check("stall_busy_after", busy, 0);

        // full FIFO, then release and drain in order
        master_waitrequest = 1'b1;
        w0 = writes_done;
        for (int i = 0; i < 4; i++) send(20 + i, 5, 32'hA0000000 + i);
        pix_x = 10'd24;
        pix_color = 32'hA0000004;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("full_pix_ready", pix_ready, 0);
        end
        step();
        master_waitrequest = 1'b0;
        send(24, 5, 32'hA0000004);
        send(25, 5, 32'hA0000005);
        pix_valid = 1'b0;
        repeat (10) step();
        check("full_write_count", writes_done - w0, 6);

        // out-of-range pixels
        w0 = writes_done;
        send(640, 0, 32'h0BAD0001);
        send(0, 480, 32'h0BAD0002);
        pix_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("oor_busy", busy, 0);
            check("oor_write", master_write, 0);
        end
        check("oor_drop_count", drop_count, 2);
        step();
        check("oor_write_count", writes_done - w0, 0);

        // last in-range pixel
        send(639, 479, 32'hCAFEF00D);
        pix_valid = 1'b0;
        wait_write(10);
        check("corner_address", master_address, 26'h22BFFC);
        repeat (3) step();

        // streaming burst, one write per cycle
        w0 = writes_done;
        for (int i = 0; i < 8; i++) send(i * 7, i + 3, 32'hC0DE0000 + i);
        pix_valid = 1'b0;
        repeat (10) step();
        check("burst_write_count", writes_done - w0, 8);

        // reset mid-write
        master_waitrequest = 1'b1;
        w0 = writes_done;
        for (int i = 0; i < 3; i++) send(100 + i, 7, 32'h5EED0000 + i);
        pix_valid = 1'b0;
        wait_write(10);
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("reset_async_write", master_write, 0);
        check("reset_async_busy", busy, 0);
        repeat (2) step();
        reset = 1'b1;
        master_waitrequest = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("post_reset_write", master_write, 0);
            check("post_reset_busy", busy, 0);
            check("post_reset_ready", pix_ready, 1);
        end
        check("reset_write_count", writes_done - w0, 0);
        step();

`ifdef FB_CLEAR_EN
        // clear engine on a 4x2 frame with one pixel queued
        c_x = 10'd1;
        c_y = 9'd1;
        c_color = 32'h12345678;
        c_valid = 1'b1;
        step();
        c_valid = 1'b0;
        c_start = 1'b1;
        c_clr_color = 32'h00FF00FF;
        step();
        c_start = 1'b0;
        c_n = 0;
        c_last = -1;
        c_fall = -1;
        for (int i = 0; i < 40 && c_fall < 0; i++) begin
            @(negedge clock);
            if (!c_busy) begin
                c_fall = cyc;
            end else begin
                check("clear_pix_ready", c_ready, 0);
                if (c_write && !c_wait && c_n < 16) begin
                    c_wa[c_n] = c_addr;
                    c_wd[c_n] = c_data;
                    c_n++;
                    c_last = cyc;
                end
            end
        end
        check("clear_write_count", c_n, 9);
        check("clear_first_addr", c_wa[0], 26'h14);
        check("clear_first_data", c_wd[0], 32'h12345678);
        for (int k = 1; k < 9 && k < c_n; k++) begin
            check("clear_addr", c_wa[k], (k - 1) * 4);
            check("clear_data", c_wd[k], 32'h00FF00FF);
        end
        check("clear_busy_fall", c_fall - c_last, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
